pkt_id_sequencer: RTL and testbench

//  Beat-level controller for the 64-byte packet-identifier datapath (GenDataPath/check_byte chain).

---
 rtl/pkt_id_sequencer_if.sv | 49 ++++
 rtl/pkt_id_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_pkt_id_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_id_sequencer_if.sv
// ---------------------------------------------------------------------------
// pkt_id_sequencer_if
// Bundles the three buses that the packet-identifier sequencer sits between:
//   in_*   upstream beat stream (valid/ready, 512-bit data, per-byte D/K and
//          byte-valid flags)
//   dp_*   the combinational GenDataPath/check_byte chain (data out, framing
//          carry in; per-byte types and framing carry back)
//   out_*  registered downstream beat stream with sop/eop/err strobes
// Modports:
//   slave   the sequencer's view
//   master  the surrounding environment's view (source, sink and datapath)
// ---------------------------------------------------------------------------
interface pkt_id_sequencer_if #(
  parameter int DATA_W = 512,
  parameter int NB     = DATA_W / 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [NB-1:0]     in_dk;
  logic [NB-1:0]     in_bvalid;

  logic [DATA_W-1:0] dp_data;
  logic [NB-1:0]     dp_dk;
  logic [NB-1:0]     dp_valid;
  logic [1:0]        dp_carry_in;
  logic [1:0]        dp_carry_out;
  logic [3*NB-1:0]   dp_type;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [3*NB-1:0]   out_type;
  logic              out_sop;
  logic              out_eop;
  logic              out_err;

  modport slave (
    input  in_valid, in_data, in_dk, in_bvalid, out_ready, dp_carry_out, dp_type,
    output in_ready, dp_data, dp_dk, dp_valid, dp_carry_in,
           out_valid, out_data, out_type, out_sop, out_eop, out_err
  );

  modport master (
    output in_valid, in_data, in_dk, in_bvalid, out_ready, dp_carry_out, dp_type,
    input  in_ready, dp_data, dp_dk, dp_valid, dp_carry_in,
           out_valid, out_data, out_type, out_sop, out_eop, out_err
  );
endinterface

// File: rtl/pkt_id_sequencer.sv
// ---------------------------------------------------------------------------
// pkt_id_sequencer
// Beat-level controller for the 64-byte packet-identifier datapath. Holds the
// cross-beat framing state ({tlp,dllp}) in a register and feeds it to byte 0
// of the datapath, replacing the old combinational byte63->byte0 wrap. Adds
// valid/ready flow control with a single output register stage, sop/eop
// strobes, framing-error detection and saturating statistics counters.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   bus (slave)       in_* upstream stream, dp_* datapath, out_* downstream
//   tlp_cnt           TLP end bytes seen (saturating)
//   dllp_cnt          DLLP end bytes seen (saturating)
//   err_cnt           beats flagged with out_err (saturating)
//
// Build option:
//   PKT_ID_STATS_EN   defined: counters implemented; undefined: no counter
//                     flops and the three counter ports read 0.
// ---------------------------------------------------------------------------
module pkt_id_sequencer #(
  parameter int DATA_W = 512,
  parameter int NB     = DATA_W / 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  pkt_id_sequencer_if.slave bus,
  output logic [CNT_W-1:0]  tlp_cnt,
  output logic [CNT_W-1:0]  dllp_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [2:0] {
    T_IDLE      = 3'b000,
    T_STP       = 3'b001,
    T_TLP_BODY  = 3'b010,
    T_TLP_END   = 3'b011,
    T_SDP       = 3'b100,
    T_DLLP_BODY = 3'b101,
    T_DLLP_END  = 3'b110,
    T_ERR       = 3'b111
  } byte_type_e;

  typedef enum logic [1:0] {
    FR_IDLE    = 2'b00,
    FR_DLLP    = 2'b01,
    FR_TLP     = 2'b10,
    FR_ILLEGAL = 2'b11
  } frame_e;

  frame_e            carry_q, carry_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [3*NB-1:0]   out_type_q, out_type_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic              out_err_q, out_err_d;

  logic              accept;
  logic              beat_sop, beat_eop, beat_err;
  frame_e            walk_st;
  byte_type_e        bt;

  // Ready depends only on registered state and the sink, never on in_valid.
  assign bus.in_ready    = !out_valid_q || bus.out_ready;
  assign accept          = bus.in_valid && bus.in_ready;

  assign bus.dp_data     = bus.in_data;
  assign bus.dp_dk       = bus.in_dk;
  assign bus.dp_valid    = bus.in_bvalid & {NB{bus.in_valid}};
  assign bus.dp_carry_in = carry_q;

  // Walk the byte types from byte 0 upward, tracking the framing state in
  // front of each byte so a start byte inside an open packet is flagged.
  // Idle, invalid and error bytes leave the state untouched, matching the
  // datapath's carry propagation across non-valid bytes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    beat_sop = 1'b0;
    beat_eop = 1'b0;
    beat_err = 1'b0;
    walk_st  = carry_q;
    bt       = T_IDLE;
    for (int i = 0; i < NB; i++) begin
      bt = byte_type_e'(bus.dp_type[3*i +: 3]);
      case (bt)
        T_STP, T_SDP: begin
          beat_sop = 1'b1;
          if (walk_st != FR_IDLE) beat_err = 1'b1;
        end
        T_TLP_END, T_DLLP_END: beat_eop = 1'b1;
        T_ERR:                 beat_err = 1'b1;
        default: ;
      endcase
      case (bt)
        T_STP, T_TLP_BODY:     walk_st = FR_TLP;
        T_SDP, T_DLLP_BODY:    walk_st = FR_DLLP;
        T_TLP_END, T_DLLP_END: walk_st = FR_IDLE;
        default: ;
      endcase
    end
    if (bus.dp_carry_out == FR_ILLEGAL) beat_err = 1'b1;
  end

  // Output stage next state: load on accept, drop valid once the sink takes
  // the beat, otherwise hold (covers the stall case).
  always_comb begin
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_type_d  = out_type_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data;
      out_type_d  = bus.dp_type;
      out_sop_d   = beat_sop;
      out_eop_d   = beat_eop;
      out_err_d   = beat_err;
      // An illegal {1,1} carry is already reported via beat_err; restart idle.
      carry_d     = (bus.dp_carry_out == FR_ILLEGAL) ? FR_IDLE : frame_e'(bus.dp_carry_out);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q     <= FR_IDLE;
      out_valid_q <= 1'b0;
      // NOTE: the wide data/type registers are reset as well so they read 0 after reset.
      out_data_q  <= '0;
      out_type_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only.
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_type_q  <= out_type_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_type  = out_type_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_err   = out_err_q;

`ifdef PKT_ID_STATS_EN
  localparam int NW = $clog2(NB + 1);

  logic [NW-1:0]    n_tlp_end, n_dllp_end;
  logic [CNT_W-1:0] tlp_cnt_q, tlp_cnt_d;
  logic [CNT_W-1:0] dllp_cnt_q, dllp_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    n_tlp_end  = '0;
    n_dllp_end = '0;
    for (int i = 0; i < NB; i++) begin
      if (bus.dp_type[3*i +: 3] == T_TLP_END)  n_tlp_end  = n_tlp_end  + NW'(1);
      if (bus.dp_type[3*i +: 3] == T_DLLP_END) n_dllp_end = n_dllp_end + NW'(1);
    end
  end

  always_comb begin
    tlp_cnt_d  = tlp_cnt_q;
    dllp_cnt_d = dllp_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (accept) begin
      tlp_cnt_d  = sat_add(tlp_cnt_q,  CNT_W'(n_tlp_end));
      dllp_cnt_d = sat_add(dllp_cnt_q, CNT_W'(n_dllp_end));
      err_cnt_d  = sat_add(err_cnt_q,  CNT_W'(beat_err));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tlp_cnt_q  <= '0;
      dllp_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      tlp_cnt_q  <= tlp_cnt_d;
      dllp_cnt_q <= dllp_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign tlp_cnt  = tlp_cnt_q;
  assign dllp_cnt = dllp_cnt_q;
  assign err_cnt  = err_cnt_q;
`else
  assign tlp_cnt  = '0;
  assign dllp_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_pkt_id_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pkt_id_sequencer
// Drives beats built from K symbols (STP=FB, SDP=5C, END=FD) and data bytes,
// closes the loop with a small behavioural datapath, and scoreboards every
// output beat against a symbol-level model of framing, strobes and counters.
// Counters are instantiated 8 bits wide so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_pkt_id_sequencer;
  localparam int DATA_W = 512;
  localparam int NB     = 64;
  localparam int CNT_W  = 8;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] tlp_cnt, dllp_cnt, err_cnt;

  pkt_id_sequencer_if #(.DATA_W(DATA_W), .NB(NB)) bus ();

  pkt_id_sequencer #(.DATA_W(DATA_W), .NB(NB), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tlp_cnt  (tlp_cnt),
    .dllp_cnt (dllp_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural datapath ----------------
  logic       force_c11;
  logic [1:0] dp_st;
  logic [7:0] dp_b;
  logic [2:0] dp_t;

  always_comb begin
    dp_st       = bus.dp_carry_in;
    dp_b        = '0;
    dp_t        = '0;
    bus.dp_type = '0;
    for (int i = 0; i < NB; i++) begin
      dp_b = bus.dp_data[8*i +: 8];
      dp_t = 3'b000;
      if (bus.dp_valid[i]) begin
        if (bus.dp_dk[i] && dp_b == K_STP) begin
          dp_t = 3'b001; dp_st = 2'b10;
        end else if (bus.dp_dk[i] && dp_b == K_SDP) begin
          dp_t = 3'b100; dp_st = 2'b01;
        end else if (bus.dp_dk[i] && dp_b == K_END) begin
          dp_t  = (dp_st == 2'b10) ? 3'b011 : (dp_st == 2'b01) ? 3'b110 : 3'b111;
          dp_st = 2'b00;
        end else if (!bus.dp_dk[i]) begin
          dp_t = (dp_st == 2'b10) ? 3'b010 : (dp_st == 2'b01) ? 3'b101 : 3'b000;
        end
      end
      bus.dp_type[3*i +: 3] = dp_t;
    end
    bus.dp_carry_out = force_c11 ? 2'b11 : dp_st;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [3*NB-1:0]   typ;
    logic              sop, eop, err;
    logic [1:0]        carry;
    logic [CNT_W-1:0]  tlp, dllp, errc;
  } exp_t;

  exp_t             sb[$];
  logic [1:0]       m_carry;
  logic [CNT_W-1:0] m_tlp, m_dllp, m_errc;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s > (1 << CNT_W) - 1) return {CNT_W{1'b1}};
    return CNT_W'(s);
  endfunction

  exp_t       e;
  logic [1:0] st;
  logic [7:0] sym;
  int         nt, nd;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        check("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_type", bus.out_type, e.typ);
          check("out_sop",  bus.out_sop,  e.sop);
          check("out_eop",  bus.out_eop,  e.eop);
          check("out_err",  bus.out_err,  e.err);
          check("carry_q",  bus.dp_carry_in, e.carry);
          check("tlp_cnt",  tlp_cnt,  e.tlp);
          check("dllp_cnt", dllp_cnt, e.dllp);
          check("err_cnt",  err_cnt,  e.errc);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        check("dp_carry_in_at_accept", bus.dp_carry_in, m_carry);
        check("dp_valid", bus.dp_valid, bus.in_bvalid);
        e.sop = 1'b0; e.eop = 1'b0; e.err = 1'b0;
        nt = 0; nd = 0;
        st = m_carry;
        for (int i = 0; i < NB; i++) begin
          sym = bus.in_data[8*i +: 8];
          if (bus.in_bvalid[i] && bus.in_dk[i]) begin
            if (sym == K_STP || sym == K_SDP) begin
              e.sop = 1'b1;
              if (st != 2'b00) e.err = 1'b1;
              st = (sym == K_STP) ? 2'b10 : 2'b01;
            end else if (sym == K_END) begin
              if (st == 2'b00) e.err = 1'b1;
              else begin
                e.eop = 1'b1;
                if (st == 2'b10) nt++; else nd++;
              end
              st = 2'b00;
            end
          end
        end
        if (force_c11) begin
          e.err = 1'b1;
          st    = 2'b00;
        end
        m_carry = st;
`ifdef PKT_ID_STATS_EN
        m_tlp  = sat(m_tlp, nt);
        m_dllp = sat(m_dllp, nd);
        m_errc = sat(m_errc, int'(e.err));
`endif
        e.data  = bus.in_data;
        e.typ   = bus.dp_type;
        e.carry = m_carry;
        e.tlp   = m_tlp;
        e.dllp  = m_dllp;
        e.errc  = m_errc;
        sb.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [DATA_W-1:0] b_data;
  logic [NB-1:0]     b_dk, b_bv;
  bit                rand_bp = 1'b0;

  always @(posedge clk) if (rand_bp) begin
    #1;
    bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic beat_idle();
    for (int i = 0; i < NB; i++) b_data[8*i +: 8] = 8'($urandom);
    b_dk = '0;
    b_bv = '1;
  endtask

  task automatic put_sym(input int i, input logic [7:0] s);
    b_data[8*i +: 8] = s;
    b_dk[i]          = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_within_bound", ok, 1'b1);
  endtask

  task automatic send(input logic frc);
    bus.in_data   = b_data;
    bus.in_dk     = b_dk;
    bus.in_bvalid = b_bv;
    force_c11     = frc;
    bus.in_valid  = 1'b1;
    wait_accept();
    bus.in_valid  = 1'b0;
    force_c11     = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    sb.delete();
    m_carry = 2'b00; m_tlp = '0; m_dllp = '0; m_errc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  logic [DATA_W-1:0] a_data;
  int                t0;
  logic [CNT_W-1:0]  sat_exp;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_dk = '0; bus.in_bvalid = '0;
    bus.out_ready = 1'b1; force_c11 = 1'b0;
    m_carry = 2'b00; m_tlp = '0; m_dllp = '0; m_errc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_sop",   bus.out_sop,   1'b0);
    check("rst_out_eop",   bus.out_eop,   1'b0);
    check("rst_out_err",   bus.out_err,   1'b0);
    check("rst_out_data",  bus.out_data,  '0);
    check("rst_out_type",  bus.out_type,  '0);
    check("rst_carry",     bus.dp_carry_in, 2'b00);
    check("rst_tlp_cnt",   tlp_cnt,  '0);
    check("rst_dllp_cnt",  dllp_cnt, '0);
    check("rst_err_cnt",   err_cnt,  '0);
    check("rst_in_ready",  bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Whole TLP in one beat.
    beat_idle(); put_sym(0, K_STP); put_sym(63, K_END); send(1'b0);

    // TLP spanning three beats.
    beat_idle(); put_sym(60, K_STP); send(1'b0);
    beat_idle(); send(1'b0);
    beat_idle(); put_sym(5, K_END); send(1'b0);

    // DLLP plus a second TLP in one beat.
    beat_idle(); put_sym(10, K_SDP); put_sym(15, K_END);
    put_sym(20, K_STP); put_sym(30, K_END); send(1'b0);

    // STP inside an open TLP, then a normal close.
    beat_idle(); put_sym(0, K_STP); send(1'b0);
    beat_idle(); put_sym(0, K_STP); send(1'b0);
    beat_idle(); put_sym(3, K_END); send(1'b0);

    // END while idle (error type) and an illegal carry-out.
    beat_idle(); put_sym(5, K_END); send(1'b0);
    beat_idle(); put_sym(63, K_STP); send(1'b1);
    beat_idle(); send(1'b0);

    // Beat with no valid bytes in the middle of a TLP.
    beat_idle(); put_sym(62, K_STP); send(1'b0);
    beat_idle(); b_bv = '0; send(1'b0);
    beat_idle(); put_sym(0, K_END); send(1'b0);

    // Stall: sink not ready for three cycles with a beat waiting.
    beat_idle(); put_sym(2, K_STP); send(1'b0);
    a_data = b_data;
    bus.out_ready = 1'b0;
    beat_idle(); put_sym(2, K_END);
    bus.in_data = b_data; bus.in_dk = b_dk; bus.in_bvalid = b_bv; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_out_data", bus.out_data, a_data);
      check("stall_carry",    bus.dp_carry_in, 2'b10);
      check("stall_tlp_cnt",  tlp_cnt, m_tlp);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;

    // Back-to-back throughput.
    t0 = int'($time);
    for (int k = 0; k < 8; k++) begin
      beat_idle();
      if (k % 2 == 0) put_sym(k, K_STP); else put_sym(k * 3, K_END);
      send(1'b0);
    end
    check("throughput_cycles", (int'($time) - t0) / 10, 8);

    // Random backpressure with random symbol mixes.
    rand_bp = 1'b1;
    for (int r = 0; r < 16; r++) begin
      beat_idle();
      repeat ($urandom_range(0, 4)) begin
        case ($urandom_range(0, 2))
          0:       put_sym($urandom_range(0, NB - 1), K_STP);
          1:       put_sym($urandom_range(0, NB - 1), K_SDP);
          default: put_sym($urandom_range(0, NB - 1), K_END);
        endcase
      end
      if ($urandom_range(0, 3) == 0) b_bv = {$urandom, $urandom};
      send(1'b0);
    end
    rand_bp = 1'b0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Saturation: 32 TLPs per beat pushes the 8-bit counter past 255.
    for (int k = 0; k < 9; k++) begin
      beat_idle();
      for (int j = 0; j < NB / 2; j++) begin
        put_sym(2 * j, K_STP);
        put_sym(2 * j + 1, K_END);
      end
      send(1'b0);
    end
    @(negedge clk);
`ifdef PKT_ID_STATS_EN
    sat_exp = {CNT_W{1'b1}};
`else
    sat_exp = '0;
`endif
    check("tlp_cnt_saturated", tlp_cnt, sat_exp);
    @(posedge clk); #1;

    // Reset mid-packet with a beat held in the output register.
    beat_idle(); put_sym(60, K_STP); send(1'b0);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_carry",     bus.dp_carry_in, 2'b00);
    check("midrst_tlp_cnt",   tlp_cnt,  '0);
    check("midrst_dllp_cnt",  dllp_cnt, '0);
    check("midrst_err_cnt",   err_cnt,  '0);
    @(posedge clk); #1;
    beat_idle(); send(1'b0);
    beat_idle(); put_sym(1, K_SDP); put_sym(9, K_END); send(1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
